// File: rtl/seq_pkg.sv
// seq_pkg: state encodings and detect pattern shared by the seq_* generator and detectors
package seq_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_t;
   localparam logic [2:0] SEQ_001 = 3'b001;
endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: request + serial-out bundle; match_cnt exists only with SEQ_PATTERN_GEN_MATCH_CNT_EN
interface seq_pattern_gen_if #(
   parameter int W     = 8,
   parameter int CNT_W = 4,
   parameter int LEN_W = 4
);
   logic             start;
   logic [W-1:0]     pattern;
   logic [LEN_W-1:0] len;
   logic [CNT_W-1:0] reps;
   logic             out;
   logic             out_valid;
   logic             busy;
   logic             done;
   logic [1:0]       pre_s;
   logic [1:0]       next_s;
`ifdef SEQ_PATTERN_GEN_MATCH_CNT_EN
   logic [7:0]       match_cnt;
   modport master (output start, pattern, len, reps,
                   input  out, out_valid, busy, done, pre_s, next_s, match_cnt);
   modport slave  (input  start, pattern, len, reps,
                   output out, out_valid, busy, done, pre_s, next_s, match_cnt);
`else
   modport master (output start, pattern, len, reps,
                   input  out, out_valid, busy, done, pre_s, next_s);
   modport slave  (input  start, pattern, len, reps,
                   output out, out_valid, busy, done, pre_s, next_s);
`endif
endinterface

// File: rtl/seq_shreg.sv
// seq_shreg: loadable W-bit left-shift register, msb is the bit on the wire
module seq_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic [0:0]   msb
);
   logic [W-1:0] q;
   // load wins over shift so a repetition reload needs no bubble
   always_ff @(posedge clk or posedge reset)
      if (reset) q <= '0;
      else if (load) q <= din;
      else if (shift) q <= q << 1;
   assign msb = q[W-1];
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern generator; SEQ_PATTERN_GEN_MATCH_CNT_EN adds a "001" counter
module seq_pattern_gen
   import seq_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = 4,
   parameter int LEN_W = 4
) (
   input logic             clk,
   input logic             reset,
   seq_pattern_gen_if.slave io
);
   state_t           pre, nxt;
   logic [LEN_W-1:0] len_e, len_q, bit_cnt;
   logic [CNT_W-1:0] rep_cnt;
   logic [W-1:0]     pat_al, pat_q;
   logic             last_bit, reload, sh_load, sh_shift;
   logic [0:0]       msb;
   assign len_e    = (io.len == '0 || 32'(io.len) > W) ? LEN_W'(W) : io.len;
   assign pat_al   = io.pattern << (W - 32'(len_e));
   assign last_bit = bit_cnt == '0;
   assign reload   = pre == ST_SHIFT && last_bit && rep_cnt != '0;
   assign sh_load  = pre == ST_LOAD || reload;
   assign sh_shift = pre == ST_SHIFT;
   seq_shreg #(.W(W)) u_shreg (
      .clk   (clk),
      .reset (reset),
      .load  (sh_load),
      .shift (sh_shift),
      .din   (pre == ST_LOAD ? pat_al : pat_q),
      .msb   (msb)
   );
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) pre <= ST_IDLE;
      else pre <= nxt;
   // next state: start only matters in IDLE, SHIFT leaves after the last bit of the last copy
   always_comb begin
      nxt = pre;
      case (pre)
         ST_IDLE:  nxt = io.start ? ST_LOAD : ST_IDLE;
         ST_LOAD:  nxt = ST_SHIFT;
         ST_SHIFT: nxt = (last_bit && rep_cnt == '0) ? ST_DONE : ST_SHIFT;
         default:  nxt = ST_IDLE;
      endcase
   end
   // capture request in LOAD, then count bits and repetitions while shifting
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pat_q   <= '0;
         len_q   <= '0;
         bit_cnt <= '0;
         rep_cnt <= '0;
      end else if (pre == ST_LOAD) begin
         pat_q   <= pat_al;
         len_q   <= len_e;
         bit_cnt <= len_e - LEN_W'(1);
         rep_cnt <= io.reps;
      end else if (reload) begin
         bit_cnt <= len_q - LEN_W'(1);
         rep_cnt <= rep_cnt - CNT_W'(1);
      end else if (pre == ST_SHIFT && !last_bit) begin
         bit_cnt <= bit_cnt - LEN_W'(1);
      end
   assign io.out       = pre == ST_SHIFT && msb[0];
   assign io.out_valid = pre == ST_SHIFT;
   assign io.busy      = pre == ST_LOAD || pre == ST_SHIFT;
   assign io.done      = pre == ST_DONE;
   assign io.pre_s     = pre;
   assign io.next_s    = nxt;
`ifdef SEQ_PATTERN_GEN_MATCH_CNT_EN
   logic [1:0] hist, hv;
   logic [7:0] mcnt;
   logic       hit;
   assign hit = hv[1] && {hist, msb} == SEQ_001;
   // slide a 3-bit window over emitted bits; hv marks how many history bits are real
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hist <= '0;
         hv   <= '0;
         mcnt <= '0;
      end else if (pre == ST_LOAD) begin
         hist <= '0;
         hv   <= '0;
         mcnt <= '0;
      end else if (pre == ST_SHIFT) begin
         hist <= {hist[0], msb[0]};
         hv   <= {hv[0], 1'b1};
         if (hit && mcnt != 8'hFF) mcnt <= mcnt + 8'd1;
      end
   assign io.match_cnt = mcnt;
`endif
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: table vectors, corner sequences and randomized transfers against a stream model
module tb_seq_pattern_gen;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   seq_pattern_gen_if #(.W(8), .CNT_W(4), .LEN_W(4)) io ();
   seq_pattern_gen #(.W(8), .CNT_W(4), .LEN_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io.slave)
   );

   typedef struct {
      logic [7:0]  p;
      logic [3:0]  l;
      logic [3:0]  r;
      logic [15:0] bits;
      int          n;
      int          m;
   } vec_t;

   int pass_n = 0;
   int total_n = 0;
   int busy_n, done_n, idle_n, loads;
   logic got_q[$];
   logic exp_q[$];
   logic [1:0] st_q[$];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total_n++;
      if (got === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic cmp_stream(input string nm);
      logic [63:0] g, e;
      g = '0;
      e = '0;
      foreach (got_q[i]) g = {g[62:0], got_q[i]};
      foreach (exp_q[i]) e = {e[62:0], exp_q[i]};
      chk({nm, "_nbits"}, 64'(got_q.size()), 64'(exp_q.size()));
      chk({nm, "_bits"}, g, e);
   endtask

   task automatic model(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
      int le;
      le = (l == 0 || l > 8) ? 8 : int'(l);
      exp_q.delete();
      for (int k = 0; k <= int'(r); k++)
         for (int b = le - 1; b >= 0; b--) exp_q.push_back(p[b]);
   endtask

   function automatic int model_match();
      int m = 0;
      for (int i = 2; i < exp_q.size(); i++)
         if (!exp_q[i-2] && !exp_q[i-1] && exp_q[i]) m++;
      return m > 255 ? 255 : m;
   endfunction

   task automatic xfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
      got_q.delete();
      st_q.delete();
      busy_n = 0;
      done_n = 0;
      @(negedge clk);
      st_q.push_back(io.pre_s);
      io.pattern = p;
      io.len = l;
      io.reps = r;
      io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         st_q.push_back(io.pre_s);
         if (io.out_valid) got_q.push_back(io.out);
         if (io.busy) busy_n++;
         if (io.done) done_n++;
         if (io.pre_s == 2'b00) break;
         @(negedge clk);
      end
   endtask

   task automatic check_xfer(input string nm, input int exp_match);
      logic [63:0] st;
      cmp_stream(nm);
      chk({nm, "_busy"}, 64'(busy_n), 64'(exp_q.size() + 1));
      chk({nm, "_done"}, 64'(done_n), 64'd1);
      chk({nm, "_idle"}, 64'(io.pre_s), 64'd0);
`ifdef SEQ_PATTERN_GEN_MATCH_CNT_EN
      chk({nm, "_match"}, 64'(io.match_cnt), 64'(exp_match));
`else
      st = 64'(exp_match);
`endif
   endtask

   initial begin
      vec_t tv[5];
      logic [63:0] st;
      tv[0] = '{8'b001, 4'd3, 4'd0, 16'b001, 3, 1};
      tv[1] = '{8'b001, 4'd3, 4'd2, 16'b001001001, 9, 3};
      tv[2] = '{8'hA5, 4'd0, 4'd0, 16'hA5, 8, 1};
      tv[3] = '{8'hA5, 4'd9, 4'd0, 16'hA5, 8, 1};
      tv[4] = '{8'h01, 4'd1, 4'd15, 16'hFFFF, 16, 0};
      io.start = 1'b0;
      io.pattern = '0;
      io.len = '0;
      io.reps = '0;
      #1;
      chk("reset_state", 64'({io.pre_s, io.out, io.out_valid, io.busy, io.done}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      foreach (tv[i]) begin
         xfer(tv[i].p, tv[i].l, tv[i].r);
         exp_q.delete();
         for (int b = tv[i].n - 1; b >= 0; b--) exp_q.push_back(tv[i].bits[b]);
         check_xfer($sformatf("tv%0d", i), tv[i].m);
         if (i == 0) begin
            st = '0;
            foreach (st_q[k]) st = {st[61:0], st_q[k]};
            chk("tv0_state_trace", st, 64'b00_01_10_10_10_11_00);
            chk("tv0_trace_len", 64'(st_q.size()), 64'd7);
         end
      end

      got_q.delete();
      done_n = 0;
      idle_n = 0;
      loads = 0;
      @(negedge clk);
      io.pattern = 8'b0110;
      io.len = 4'd4;
      io.reps = 4'd0;
      io.start = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (io.out_valid) got_q.push_back(io.out);
         if (io.done) done_n++;
         if (io.pre_s == 2'b00) idle_n++;
         if (io.pre_s == 2'b10 && loads == 1) io.pattern = 8'hFF;
         if (io.pre_s == 2'b01) begin
            loads++;
            if (loads == 2) io.start = 1'b0;
         end
         if (done_n == 2) break;
      end
      io.start = 1'b0;
      exp_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      cmp_stream("held_start");
      chk("held_start_done", 64'(done_n), 64'd2);
      chk("held_start_idle_gap", 64'(idle_n), 64'd1);
      @(negedge clk);

      @(negedge clk);
      io.pattern = 8'hA5;
      io.len = 4'd8;
      io.reps = 4'd1;
      io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_outputs", 64'({io.pre_s, io.out, io.out_valid, io.busy, io.done}), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      done_n = 0;
      repeat (3) begin
         @(negedge clk);
         if (io.done || io.busy) done_n++;
      end
      chk("abort_no_done", 64'(done_n), 64'd0);
      xfer(8'hC3, 4'd7, 4'd1);
      model(8'hC3, 4'd7, 4'd1);
      check_xfer("after_abort", model_match());

      for (int t = 0; t < 25; t++) begin
         logic [7:0] p;
         logic [3:0] l, r;
         p = 8'($urandom);
         l = 4'($urandom_range(0, 15));
         r = 4'($urandom_range(0, 3));
         xfer(p, l, r);
         model(p, l, r);
         check_xfer($sformatf("rnd%0d_p%0h_l%0d_r%0d", t, p, l, r), model_match());
      end

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-pattern generator; the transmit-side counterpart of the team's serial sequence detectors.
- Captures a programmable pattern word and length, then shifts it out MSB-first, one bit per clock, repeated a programmable number of times.
- Drives detector `in` ports in bench and on-board loopback.
- Exposes present/next FSM state, as the detector does, for debug on LEDs/ILA.

Parameters:
- W, 8: pattern register width in bits.
- CNT_W, 4: repetition-count width.
- LEN_W, 4: length-field width; must hold the value W (W=8 needs 4).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a transfer; sampled only in IDLE.
- pattern  input  W  pattern bits; pattern[len-1] is sent first.
- len  input  LEN_W  bits per repetition, 1..W; 0 or any value >W means W.
- reps  input  CNT_W  extra repetitions; reps+1 copies are sent.
- out  output  1  serial data bit, registered.
- out_valid  output  1  high on every cycle carrying a pattern bit.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  one-cycle pulse in DONE.
- pre_s  output  2  present state.
- next_s  output  2  next state, combinational.

Behaviour:
- Reset (async, immediate, no clock needed): pre_s=IDLE, out=0, out_valid=0, busy=0, done=0; shift register and counters cleared.
- States: IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11.
- IDLE: out=0, out_valid=0. start=1 -> LOAD; otherwise stay.
- LOAD (1 cycle):
  - shreg <= pattern << (W-len_eff); pattern copy also held.
  - bit_cnt <= len_eff-1; rep_cnt <= reps.
  - -> SHIFT.
- SHIFT:
  - out=shreg[W-1], out_valid=1, busy=1.
  - Each cycle: shreg shifts left; bit_cnt decrements.
  - bit_cnt==0 and rep_cnt!=0: reload shreg from held copy, bit_cnt <= len_eff-1, rep_cnt decrements, stay in SHIFT. No bubble between repetitions.
  - bit_cnt==0 and rep_cnt==0: -> DONE.
- DONE (1 cycle): done=1, out=0, out_valid=0 -> IDLE.
- Latency:
  - start sampled high at edge k: state is LOAD after k, first valid bit after edge k+1.
  - Transfer occupies (len_eff*(reps+1)) SHIFT cycles + LOAD + DONE.
- start while busy or in DONE is ignored; no queueing. If start is still high in the next IDLE cycle, the next transfer is accepted.
- pattern/len/reps are captured in LOAD only; changes during the transfer have no effect.
- Reset mid-transfer aborts immediately. No done pulse; partial output is discarded.
- next_s is pure combinational from pre_s, start and the counters; pre_s is next_s registered.

Optional Feature:
- Macro: SEQ_PATTERN_GEN_MATCH_CNT_EN.
- Defined:
  - Adds output match_cnt [7:0]: count of "001" occurrences in the emitted bit stream, overlapping windows included, across repetition boundaries.
  - History register and count are cleared in LOAD and held after DONE until the next LOAD.
  - Saturates at 8'hFF.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package/include seq_pkg holds:
  - state encodings ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE (2-bit);
  - detect pattern constant SEQ_001 = 3'b001, shared with the detectors.
- One natural sub-module: seq_shreg.
  - Loadable W-bit left-shift register.
  - Ports: clk, reset, load, shift, din[W-1:0], msb.
- FSM and counters stay in the top module.

Test Plan:
1. pattern=8'b001, len=3, reps=0, one-cycle start:
   - out_valid bits 0,0,1;
   - pre_s sequence 00,01,10,10,10,11,00;
   - done high exactly one cycle;
   - match_cnt=1 if the feature is enabled.
2. pattern=8'b001, len=3, reps=2:
   - nine contiguous valid bits 001001001, no gap;
   - busy high 10 cycles;
   - match_cnt=3.
3. pattern=8'hA5, len=0 -> eight bits 1,0,1,0,0,1,0,1; len=9 gives the same result.
4. Start held high throughout:
   - start pulses and pattern change to 8'hFF during SHIFT have no effect on the current transfer;
   - a second transfer begins from the IDLE cycle after DONE, using the new pattern.
5. Reset asserted between clock edges during SHIFT (4th bit):
   - out=0, out_valid=0, busy=0, pre_s=00 immediately;
   - no done pulse;
   - after release, a fresh start yields a correct full transfer.
6. pattern=8'b1, len=1, reps=15 (max) -> 16 consecutive valid 1s, done once, match_cnt=0.
